// File: rtl/dm_arbiter_if.sv
// Request/response bundle between the two DM requesters (CPU MEM stage, DMA/debug)
// and dm_arbiter. The master modport is the requester side; slave is the arbiter side.
interface dm_arbiter_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_web;
    logic [DATA_W-1:0] cpu_bweb;
    logic [ADDR_W-1:0] cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_rvalid;

    logic              dma_req;
    logic              dma_web;
    logic [DATA_W-1:0] dma_bweb;
    logic [ADDR_W-1:0] dma_addr;
    logic [DATA_W-1:0] dma_wdata;
    logic              dma_gnt;
    logic [DATA_W-1:0] dma_rdata;
    logic              dma_rvalid;

    modport master (
        output cpu_req, cpu_web, cpu_bweb, cpu_addr, cpu_wdata,
        input  cpu_stall, cpu_rdata, cpu_rvalid,
        output dma_req, dma_web, dma_bweb, dma_addr, dma_wdata,
        input  dma_gnt, dma_rdata, dma_rvalid
    );

    modport slave (
        input  cpu_req, cpu_web, cpu_bweb, cpu_addr, cpu_wdata,
        output cpu_stall, cpu_rdata, cpu_rvalid,
        input  dma_req, dma_web, dma_bweb, dma_addr, dma_wdata,
        output dma_gnt, dma_rdata, dma_rvalid
    );
endinterface

// File: rtl/dm_arbiter.sv
// Two-master arbiter for the single-port DM SRAM: fixed CPU priority, read-return routing.
// Define DM_ARB_STARVE_GUARD_EN to build the DMA starvation guard (forced grant after MAX_WAIT).
module dm_arbiter #(
    parameter int ADDR_W   = 14,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 8
) (
    input  logic              clk,
    input  logic              rst,
    dm_arbiter_if.slave       bus,
    output logic              DM_WEB,
    output logic [DATA_W-1:0] DM_BWEB,
    output logic [ADDR_W-1:0] DM_A,
    output logic [DATA_W-1:0] DM_IN,
    input  logic [DATA_W-1:0] DM_OUT
);

    typedef enum logic [1:0] {
        OWN_IDLE = 2'd0,
        OWN_CPU  = 2'd1,
        OWN_DMA  = 2'd2
    } owner_t;

    owner_t winner;
    logic   force_dma;
    logic   rd_valid;
    logic   rd_dma;

    if (MAX_WAIT < 1 || MAX_WAIT > 255) begin : g_max_wait_range
        $error("dm_arbiter: MAX_WAIT must be in 1..255");
    end

`ifdef DM_ARB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt;

    assign force_dma = bus.dma_req && (wait_cnt == MAX_CNT);

    // Counts consecutive denied DMA cycles; any grant or dropped request restarts it.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (bus.dma_req && (winner != OWN_DMA)) begin
            if (wait_cnt != MAX_CNT) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
        end else begin
            wait_cnt <= '0;
        end
    end
`else
    assign force_dma = 1'b0;
`endif

    always_comb begin
        winner = OWN_IDLE;
        if (!rst) begin
            if (force_dma) begin
                winner = OWN_DMA;
            end else if (bus.cpu_req) begin
                winner = OWN_CPU;
            end else if (bus.dma_req) begin
                winner = OWN_DMA;
            end
        end
    end

    always_comb begin
        DM_WEB  = 1'b1;
        DM_BWEB = '1;
        DM_A    = '0;
        DM_IN   = '0;
        case (winner)
            OWN_CPU: begin
                DM_WEB  = bus.cpu_web;
                DM_BWEB = bus.cpu_bweb;
                DM_A    = bus.cpu_addr;
                DM_IN   = bus.cpu_wdata;
            end
            OWN_DMA: begin
                DM_WEB  = bus.dma_web;
                DM_BWEB = bus.dma_bweb;
                DM_A    = bus.dma_addr;
                DM_IN   = bus.dma_wdata;
            end
            default: ;
        endcase
    end

    assign bus.dma_gnt = (winner == OWN_DMA);
`ifdef DM_ARB_STARVE_GUARD_EN
    assign bus.cpu_stall = bus.cpu_req && (winner == OWN_DMA);
`else
    assign bus.cpu_stall = 1'b0;
`endif

    // Single-entry tag: who owns the SRAM read data arriving next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_dma   <= 1'b0;
        end else begin
            rd_valid <= (winner != OWN_IDLE) && DM_WEB;
            rd_dma   <= (winner == OWN_DMA);
        end
    end

    // Gated by rst so a read granted just before reset never returns.
    assign bus.cpu_rvalid = !rst && rd_valid && !rd_dma;
    assign bus.dma_rvalid = !rst && rd_valid &&  rd_dma;
    assign bus.cpu_rdata  = DM_OUT;
    assign bus.dma_rdata  = DM_OUT;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed self-checking bench for dm_arbiter with a behavioural one-cycle-latency SRAM.
// Starvation expectations follow DM_ARB_STARVE_GUARD_EN as the RTL does.
module tb_dm_arbiter;
    localparam int ADDR_W = 14;
    localparam int DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              DM_WEB;
    logic [DATA_W-1:0] DM_BWEB;
    logic [ADDR_W-1:0] DM_A;
    logic [DATA_W-1:0] DM_IN;
    logic [DATA_W-1:0] DM_OUT;

    int n_tests = 0;
    int n_fail  = 0;

    dm_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dm_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(8)) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus),
        .DM_WEB  (DM_WEB),
        .DM_BWEB (DM_BWEB),
        .DM_A    (DM_A),
        .DM_IN   (DM_IN),
        .DM_OUT  (DM_OUT)
    );

    always #5 clk = ~clk;

    // SRAM model: bit-masked write, read data one cycle after the access.
    logic [DATA_W-1:0] mem [0:255];
    always @(posedge clk) begin
        DM_OUT <= mem[DM_A[7:0]];
        if (!DM_WEB)
            mem[DM_A[7:0]] <= (mem[DM_A[7:0]] & DM_BWEB) | (DM_IN & ~DM_BWEB);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_cpu(input logic req, input logic web, input logic [31:0] bweb,
                             input logic [13:0] addr, input logic [31:0] wdata);
        bus.cpu_req   = req;
        bus.cpu_web   = web;
        bus.cpu_bweb  = bweb;
        bus.cpu_addr  = addr;
        bus.cpu_wdata = wdata;
    endtask

    task automatic drive_dma(input logic req, input logic web, input logic [31:0] bweb,
                             input logic [13:0] addr, input logic [31:0] wdata);
        bus.dma_req   = req;
        bus.dma_web   = web;
        bus.dma_bweb  = bweb;
        bus.dma_addr  = addr;
        bus.dma_wdata = wdata;
    endtask

    task automatic idle();
        drive_cpu(1'b0, 1'b1, '1, '0, '0);
        drive_dma(1'b0, 1'b1, '1, '0, '0);
    endtask

    initial begin
        bit guard;
        bit exp_gnt;
        bit prev_dma_gnt;
        int n_cyc;
`ifdef DM_ARB_STARVE_GUARD_EN
        guard = 1'b1;
        n_cyc = 20;
`else
        guard = 1'b0;
        n_cyc = 100;
`endif
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[8'h10] = 32'hDEADBEEF;
        mem[8'h20] = 32'hA5A50020;

        // Reset held with both masters requesting reads
        rst = 1'b1;
        drive_cpu(1'b1, 1'b1, '1, 14'h0010, '0);
        drive_dma(1'b1, 1'b1, '1, 14'h0020, '0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rst_dma_gnt",   bus.dma_gnt,   0);
            check("rst_cpu_stall", bus.cpu_stall, 0);
            check("rst_dm_web",    DM_WEB,        1);
            check("rst_dm_bweb",   DM_BWEB,       32'hFFFFFFFF);
            check("rst_dm_a",      DM_A,          0);
            check("rst_dm_in",     DM_IN,         0);
            check("rst_cpu_rvalid", bus.cpu_rvalid, 0);
            tick();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rel_cpu_rvalid", bus.cpu_rvalid, 0);
        check("rel_dma_rvalid", bus.dma_rvalid, 0);
        tick();
        @(negedge clk);
        check("rel2_cpu_rvalid", bus.cpu_rvalid, 0);
        check("rel2_dma_rvalid", bus.dma_rvalid, 0);
        tick();

        // CPU read of 0x10
        drive_cpu(1'b1, 1'b1, '1, 14'h0010, '0);
        @(negedge clk);
        check("cpurd_dm_a",  DM_A,          32'h10);
        check("cpurd_web",   DM_WEB,        1);
        check("cpurd_stall", bus.cpu_stall, 0);
        check("cpurd_gnt",   bus.dma_gnt,   0);
        tick();
        idle();
        @(negedge clk);
        check("cpurd_rvalid",     bus.cpu_rvalid, 1);
        check("cpurd_rdata",      bus.cpu_rdata,  32'hDEADBEEF);
        check("cpurd_dma_rvalid", bus.dma_rvalid, 0);
        tick();

        // DMA read 0x20, then CPU write 0x20, then CPU read 0x20
        drive_dma(1'b1, 1'b1, '1, 14'h0020, '0);
        @(negedge clk);
        check("alt_dma_gnt",  bus.dma_gnt, 1);
        check("alt_dma_a",    DM_A,        32'h20);
        tick();
        drive_dma(1'b0, 1'b1, '1, '0, '0);
        drive_cpu(1'b1, 1'b0, 32'h0, 14'h0020, 32'h12345678);
        @(negedge clk);
        check("alt_dma_rvalid", bus.dma_rvalid, 1);
        check("alt_dma_rdata",  bus.dma_rdata,  32'hA5A50020);
        check("alt_cpu_rvalid", bus.cpu_rvalid, 0);
        check("alt_wr_web",     DM_WEB,         0);
        check("alt_wr_in",      DM_IN,          32'h12345678);
        check("alt_wr_gnt",     bus.dma_gnt,    0);
        tick();
        drive_cpu(1'b1, 1'b1, '1, 14'h0020, '0);
        @(negedge clk);
        check("wr_no_cpu_rvalid", bus.cpu_rvalid, 0);
        check("wr_no_dma_rvalid", bus.dma_rvalid, 0);
        tick();
        idle();
        @(negedge clk);
        check("alt_rd_rvalid", bus.cpu_rvalid, 1);
        check("alt_rd_rdata",  bus.cpu_rdata,  32'h12345678);
        tick();

        // CPU partial write (low half only) while DMA also requests: CPU wins
        drive_cpu(1'b1, 1'b0, 32'hFFFF0000, 14'h0030, 32'hCAFEBABE);
        drive_dma(1'b1, 1'b0, 32'h0, 14'h0031, 32'h11111111);
        @(negedge clk);
        check("prio_dma_gnt", bus.dma_gnt, 0);
        check("prio_dm_a",    DM_A,        32'h30);
        check("prio_bweb",    DM_BWEB,     32'hFFFF0000);
        tick();
        drive_dma(1'b0, 1'b1, '1, '0, '0);
        drive_cpu(1'b1, 1'b1, '1, 14'h0030, '0);
        tick();
        idle();
        @(negedge clk);
        check("bweb_rdata", bus.cpu_rdata, 32'h0000BABE);
        tick();
        @(negedge clk);
        check("bweb_mem31", mem[8'h31], 32'h0);
        tick();

        // Starvation: CPU reads continuously, DMA reads held from cycle 0
        prev_dma_gnt = 1'b0;
        for (int c = 0; c < n_cyc; c++) begin
            drive_cpu(1'b1, 1'b1, '1, 14'h0010, '0);
            drive_dma(1'b1, 1'b1, '1, 14'h0040, '0);
            exp_gnt = guard && (c == 8 || c == 17);
            @(negedge clk);
            check($sformatf("starve_gnt_c%0d", c),   bus.dma_gnt,   exp_gnt);
            check($sformatf("starve_stall_c%0d", c), bus.cpu_stall, exp_gnt);
            check($sformatf("starve_drv_c%0d", c),   DM_A, exp_gnt ? 32'h40 : 32'h10);
            check($sformatf("starve_dvld_c%0d", c),  bus.dma_rvalid, prev_dma_gnt);
            check($sformatf("starve_cvld_c%0d", c),  bus.cpu_rvalid, (c > 0) && !prev_dma_gnt);
            prev_dma_gnt = exp_gnt;
            tick();
        end
        // CPU backs off: waiting DMA is granted
        drive_cpu(1'b0, 1'b1, '1, '0, '0);
        @(negedge clk);
        check("starve_release_gnt", bus.dma_gnt, 1);
        tick();
        idle();
        tick();

        // Reset arriving right after a granted CPU read
        drive_cpu(1'b1, 1'b1, '1, 14'h0010, '0);
        @(negedge clk);
        check("rstrd_grant_a", DM_A, 32'h10);
        tick();
        rst = 1'b1;
        drive_cpu(1'b1, 1'b0, 32'h0, 14'h0010, 32'hBAD0BAD0);
        @(negedge clk);
        check("rstrd_rvalid_n1", bus.cpu_rvalid, 0);
        check("rstrd_web_n1",    DM_WEB,         1);
        tick();
        rst = 1'b0;
        idle();
        @(negedge clk);
        check("rstrd_rvalid_n2", bus.cpu_rvalid, 0);
        check("rstrd_mem_kept",  mem[8'h10],     32'hDEADBEEF);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dm_arbiter.md
# dm_arbiter

Two-master arbiter for the single-port data memory (DM) SRAM macro. It shares the DM port between the CPU load/store path in the MEM stage and a secondary DMA/debug requester. The CPU has fixed priority, and an optional starvation guard periodically forces a DMA grant while stalling the CPU. It also routes the one-cycle-latency read data back to the master that issued each read.

## Interface
- `ADDR_W`, 14: DM word-address width.
- `DATA_W`, 32: data width; `BWEB` width equals `DATA_W`.
- `MAX_WAIT`, 8: consecutive denied DMA cycles before a forced DMA grant (starvation guard only); legal range 1..255.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `cpu_req` in 1: CPU memory access this cycle.
- `cpu_web` in 1: CPU write enable, active-low (0 = write, 1 = read).
- `cpu_bweb` in `DATA_W`: CPU bit write enable, active-low.
- `cpu_addr` in `ADDR_W`: CPU word address.
- `cpu_wdata` in `DATA_W`: CPU write data.
- `cpu_stall` out 1: CPU request not accepted; CPU must hold MEM stage and re-present the identical request.
- `cpu_rdata` out `DATA_W`: read data, valid when `cpu_rvalid`=1.
- `cpu_rvalid` out 1: CPU read data valid.
- `dma_req`, `dma_web`, `dma_bweb`, `dma_addr`, `dma_wdata` in: DMA request, same meaning as the CPU signals.
- `dma_gnt` out 1: DMA request accepted this cycle.
- `dma_rdata` out `DATA_W`, `dma_rvalid` out 1: DMA read return.
- `DM_WEB` out 1, `DM_BWEB` out `DATA_W`, `DM_A` out `ADDR_W`, `DM_IN` out `DATA_W`: SRAM port.
- `DM_OUT` in `DATA_W`: SRAM read data, valid one cycle after the read cycle.

## Operation
- **Grant is combinational in the request cycle.**
  - Default winner: CPU if `cpu_req`, else DMA if `dma_req`, else idle.
  - `dma_gnt` = DMA is the winner.
  - `cpu_stall` = `cpu_req` & DMA is the winner.
- **SRAM port** is muxed from the winner.
  - Idle drives `DM_WEB`=1, `DM_BWEB`=all 1s, `DM_A`=0, `DM_IN`=0. No write can occur when idle.
- **Read return.**
  - Register `rd_tag` {valid, owner} captures (winner is reading, i.e. winner `web`=1, and the winner's id) each cycle.
  - Next cycle: `cpu_rvalid` = tag valid & owner=CPU; `dma_rvalid` = tag valid & owner=DMA.
  - `cpu_rdata` and `dma_rdata` both pass `DM_OUT` through; consumers qualify with rvalid.
  - Writes never produce rvalid.
- **DMA handshake.** `dma_req` and its payload must be held stable until `dma_gnt`; a dropped request is simply forgotten.
- **Starvation guard** (`wait_cnt`, width `$clog2(MAX_WAIT+1)`):
  - Increments when `dma_req` & !`dma_gnt`.
  - Clears when `dma_gnt` or !`dma_req`.
  - When `wait_cnt`==`MAX_WAIT` and `dma_req`, DMA wins even if `cpu_req` is high.
  - A forced grant lasts exactly one cycle; the counter clears, so the CPU wins again the following cycle.
  - `wait_cnt` saturates at `MAX_WAIT`.
- **Reset.** While `rst`=1:
  - All grants are forced idle: `dma_gnt`=0, `cpu_stall`=0, SRAM port at idle values.
  - Next edge clears `rd_tag` and `wait_cnt`.
  - A read granted in the cycle before `rst` produces no rvalid.

## Timing
- Grant and stall: 0-cycle (same cycle as request).
- Read data: 1 cycle after grant. Write: completes at the grant edge.
- Back-to-back reads from alternating masters are supported, one per cycle; `rd_tag` is a single-entry pipeline.
- Worst-case DMA wait with the guard enabled: `MAX_WAIT` cycles, then grant.
- Worst-case CPU stall per forced grant: 1 cycle.
- Reset values: `cpu_stall`=0, `dma_gnt`=0, `cpu_rvalid`=0, `dma_rvalid`=0, `DM_WEB`=1, `DM_BWEB`=32'hFFFF_FFFF, `DM_A`=0, `DM_IN`=0, `rd_tag`=0, `wait_cnt`=0.

## Configuration
- `DM_ARB_STARVE_GUARD_EN` defined: `wait_cnt` and the forced-DMA grant are present as described. `cpu_stall` can assert.
- Not defined: pure fixed CPU priority. `wait_cnt` is not built and `MAX_WAIT` is ignored. `cpu_stall` is tied 0, and DMA can starve indefinitely.

## Test plan
- **Reset:** hold `rst`=1 with both reqs high for 3 cycles → `dma_gnt`=0, `cpu_stall`=0, `DM_WEB`=1, no rvalid in the cycle after release.
- **CPU read:** `cpu_req`=1, `cpu_web`=1, `cpu_addr`=14'h0010, SRAM word 0x10=32'hDEADBEEF → next cycle `cpu_rvalid`=1, `cpu_rdata`=32'hDEADBEEF, `dma_rvalid`=0.
- **Alternating masters:** DMA read addr 0x20 (CPU idle), then next cycle CPU write addr 0x20 with 32'h12345678, `bweb`=0 → `dma_rvalid`=1 with old data in cycle 2. A subsequent CPU read returns 32'h12345678.
- **Starvation, guard on, `MAX_WAIT`=8:** `cpu_req`=1 continuously, `dma_req`=1 from cycle 0 → `dma_gnt` and `cpu_stall` high only in cycle 8, and again in cycle 17.
- **Guard off:** same stimulus for 100 cycles → `dma_gnt`=0 throughout, `cpu_stall`=0.
- **Reset mid-read:** CPU read granted in cycle N, `rst`=1 in cycle N+1 → `cpu_rvalid`=0 in N+1 and N+2.
